// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and MDU occupancy of EX.
// Optional performance counters are built only when PIPE_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
    parameter int unsigned MDU_LAT = 4,
    parameter int unsigned REG_AW  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_dst,
    input  logic              ex_mdu_start,
    input  logic              branch_taken,
    output logic              pc_we,
    output logic              ifid_we,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              exmem_hold,
    output logic              busy,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       flush_count
);

    localparam logic [1:0] RUN        = 2'd0;
    localparam logic [1:0] LOAD_STALL = 2'd1;
    localparam logic [1:0] MDU_BUSY   = 2'd2;

    logic [1:0] state_q, state_d;
    logic [3:0] mdu_cnt_q, mdu_cnt_d;
    logic       load_use;

    assign load_use = id_valid & ex_mem_read & (ex_dst != '0) &
                      ((id_use_rs & (id_rs == ex_dst)) | (id_use_rt & (id_rt == ex_dst)));

    always_comb begin
        state_d     = state_q;
        mdu_cnt_d   = mdu_cnt_q;
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_hold  = 1'b0;
        busy        = (state_q != RUN);
        case (state_q)
            MDU_BUSY: begin
                pc_we   = 1'b0;
                ifid_we = 1'b0;
                if (mdu_cnt_q == 4'd0) begin
                    idex_bubble = 1'b1;
                    state_d     = RUN;
                end else begin
                    exmem_hold = 1'b1;
                    mdu_cnt_d  = mdu_cnt_q - 4'd1;
                end
            end
            default: begin
                // LOAD_STALL lasts one cycle and only honours a (spurious) branch
                state_d = RUN;
                if (branch_taken) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (state_q == RUN && ex_mdu_start) begin
                    pc_we      = 1'b0;
                    ifid_we    = 1'b0;
                    exmem_hold = 1'b1;
                    mdu_cnt_d  = 4'(MDU_LAT - 2);
                    state_d    = MDU_BUSY;
                end else if (state_q == RUN && load_use) begin
                    pc_we       = 1'b0;
                    ifid_we     = 1'b0;
                    idex_bubble = 1'b1;
                    state_d     = LOAD_STALL;
                end
            end
        endcase
        if (!rst_n) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_hold  = 1'b0;
            busy        = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RUN;
            mdu_cnt_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            mdu_cnt_q <= mdu_cnt_d;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_q, flush_q;
    logic        flush_evt;

    assign flush_evt = branch_taken & (state_q != MDU_BUSY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= 32'd0;
            flush_q <= 32'd0;
        end else begin
            if (!pc_we)    stall_q <= stall_q + 32'd1;
            if (flush_evt) flush_q <= flush_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = 32'd0;
    assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed vector table plus random stimulus against a
// cycle-count reference model.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned MDU_LAT = 4;

    typedef struct {
        logic       rst_n;
        logic       id_valid;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       use_rs;
        logic       use_rt;
        logic       mem_read;
        logic [4:0] ex_dst;
        logic       mdu;
        logic       br;
        logic [5:0] exp; // {pc_we, ifid_we, ifid_flush, idex_bubble, exmem_hold, busy}
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs = '0;
    logic [4:0]  id_rt = '0;
    logic        id_use_rs = 1'b0;
    logic        id_use_rt = 1'b0;
    logic        ex_mem_read = 1'b0;
    logic [4:0]  ex_dst = '0;
    logic        ex_mdu_start = 1'b0;
    logic        branch_taken = 1'b0;
    logic        pc_we, ifid_we, ifid_flush, idex_bubble, exmem_hold, busy;
    logic [31:0] stall_cycles, flush_count;

    int n_chk = 0;
    int n_pass = 0;

    // Reference model: remaining freeze cycles of an MDU op and a pending one-cycle stall
    int          m_mdu_rem = 0;
    bit          m_ls = 1'b0;
    logic [31:0] m_stall = '0;
    logic [31:0] m_flush = '0;

    vec_t tbl[22];

    pipeline_hazard_ctrl #(.MDU_LAT(MDU_LAT), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_mem_read(ex_mem_read),
        .ex_dst(ex_dst), .ex_mdu_start(ex_mdu_start), .branch_taken(branch_taken),
        .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
        .exmem_hold(exmem_hold), .busy(busy), .stall_cycles(stall_cycles),
        .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic v, input logic [4:0] rs,
                                input logic [4:0] rt, input logic urs, input logic urt,
                                input logic mr, input logic [4:0] dst, input logic mdu,
                                input logic br, input logic [5:0] exp);
        vec_t t;
        t.rst_n = r; t.id_valid = v; t.id_rs = rs; t.id_rt = rt; t.use_rs = urs;
        t.use_rt = urt; t.mem_read = mr; t.ex_dst = dst; t.mdu = mdu; t.br = br; t.exp = exp;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // One clock cycle: drive, compare mid-low-phase, then advance the model to the next edge.
    task automatic step(input vec_t v, input bit use_tbl, input string name);
        logic [5:0] m_out;
        bit         hazard, take_br;
        int         nxt_rem;
        bit         nxt_ls;
        @(negedge clk);
        rst_n = v.rst_n; id_valid = v.id_valid; id_rs = v.id_rs; id_rt = v.id_rt;
        id_use_rs = v.use_rs; id_use_rt = v.use_rt; ex_mem_read = v.mem_read;
        ex_dst = v.ex_dst; ex_mdu_start = v.mdu; branch_taken = v.br;
        #1;
        if (!v.rst_n) begin
            m_mdu_rem = 0; m_ls = 1'b0; m_stall = '0; m_flush = '0;
        end
        hazard = v.id_valid && v.mem_read && v.ex_dst != 0 &&
                 ((v.use_rs && v.id_rs == v.ex_dst) || (v.use_rt && v.id_rt == v.ex_dst));
        take_br = 1'b0;
        nxt_rem = 0;
        nxt_ls  = 1'b0;
        if (!v.rst_n) begin
            m_out = 6'b001100;
        end else if (m_mdu_rem > 0) begin
            m_out   = (m_mdu_rem == 1) ? 6'b000101 : 6'b000011;
            nxt_rem = m_mdu_rem - 1;
        end else if (v.br) begin
            m_out   = {4'b1111, 1'b0, m_ls};
            take_br = 1'b1;
        end else if (!m_ls && v.mdu) begin
            m_out   = 6'b000010;
            nxt_rem = MDU_LAT - 1;
        end else if (!m_ls && hazard) begin
            m_out  = 6'b000100;
            nxt_ls = 1'b1;
        end else begin
            m_out = {5'b11000, m_ls};
        end
        chk({name, ".outs"}, 32'({pc_we, ifid_we, ifid_flush, idex_bubble, exmem_hold, busy}),
            32'(use_tbl ? v.exp : m_out));
`ifdef PIPE_PERF_CNT_EN
        chk({name, ".stall_cycles"}, stall_cycles, m_stall);
        chk({name, ".flush_count"}, flush_count, m_flush);
        if (v.rst_n) begin
            if (!m_out[5]) m_stall = m_stall + 32'd1;
            if (take_br)   m_flush = m_flush + 32'd1;
        end
`else
        chk({name, ".stall_cycles"}, stall_cycles, 32'd0);
        chk({name, ".flush_count"}, flush_count, 32'd0);
`endif
        if (v.rst_n) begin
            m_mdu_rem = nxt_rem;
            m_ls      = nxt_ls;
        end
    endtask

    initial begin
        vec_t r;
        //            rst v  rs     rt     urs urt mr dst    mdu br  exp
        tbl[0]  = mk(0, 0, 5'd0,  5'd0,  0, 0, 0, 5'd0,  0, 0, 6'b001100);
        tbl[1]  = mk(0, 0, 5'd0,  5'd0,  0, 0, 0, 5'd0,  0, 0, 6'b001100);
        tbl[2]  = mk(0, 0, 5'd0,  5'd0,  0, 0, 0, 5'd0,  0, 0, 6'b001100);
        tbl[3]  = mk(1, 0, 5'd0,  5'd0,  0, 0, 0, 5'd0,  0, 0, 6'b110000);
        tbl[4]  = mk(1, 1, 5'd23, 5'd1,  1, 0, 1, 5'd23, 0, 0, 6'b000100);
        tbl[5]  = mk(1, 1, 5'd23, 5'd1,  1, 0, 1, 5'd23, 0, 0, 6'b110001);
        tbl[6]  = mk(1, 0, 5'd0,  5'd0,  0, 0, 0, 5'd0,  0, 0, 6'b110000);
        tbl[7]  = mk(1, 1, 5'd0,  5'd0,  1, 1, 1, 5'd0,  0, 0, 6'b110000);
        tbl[8]  = mk(1, 1, 5'd23, 5'd1,  1, 0, 1, 5'd23, 0, 1, 6'b111100);
        tbl[9]  = mk(1, 0, 5'd0,  5'd0,  0, 0, 0, 5'd0,  0, 0, 6'b110000);
        tbl[10] = mk(1, 0, 5'd0,  5'd0,  0, 0, 0, 5'd0,  1, 0, 6'b000010);
        tbl[11] = mk(1, 0, 5'd0,  5'd0,  0, 0, 0, 5'd0,  1, 0, 6'b000011);
        tbl[12] = mk(1, 0, 5'd0,  5'd0,  0, 0, 0, 5'd0,  0, 1, 6'b000011);
        tbl[13] = mk(1, 0, 5'd0,  5'd0,  0, 0, 0, 5'd0,  0, 0, 6'b000101);
        tbl[14] = mk(1, 0, 5'd0,  5'd0,  0, 0, 0, 5'd0,  0, 0, 6'b110000);
        tbl[15] = mk(1, 0, 5'd0,  5'd0,  0, 0, 0, 5'd0,  1, 0, 6'b000010);
        tbl[16] = mk(0, 0, 5'd0,  5'd0,  0, 0, 0, 5'd0,  0, 0, 6'b001100);
        tbl[17] = mk(1, 0, 5'd0,  5'd0,  0, 0, 0, 5'd0,  0, 0, 6'b110000);
        tbl[18] = mk(1, 0, 5'd0,  5'd0,  0, 0, 0, 5'd0,  0, 0, 6'b110000);
        tbl[19] = mk(1, 1, 5'd2,  5'd7,  0, 1, 1, 5'd7,  0, 0, 6'b000100);
        tbl[20] = mk(1, 1, 5'd2,  5'd7,  0, 1, 1, 5'd7,  0, 1, 6'b111101);
        tbl[21] = mk(1, 0, 5'd0,  5'd0,  0, 0, 0, 5'd0,  0, 0, 6'b110000);

        for (int i = 0; i < 22; i++) begin
            step(tbl[i], 1'b1, $sformatf("vec%0d", i));
            // Load-use + branch + MDU scenarios complete by vector 13
            if (i == 14) begin
`ifdef PIPE_PERF_CNT_EN
                chk("scenario_stall_cycles", stall_cycles, 32'd5);
                chk("scenario_flush_count", flush_count, 32'd1);
`else
                chk("scenario_stall_cycles", stall_cycles, 32'd0);
                chk("scenario_flush_count", flush_count, 32'd0);
`endif
            end
        end

        for (int i = 0; i < 3000; i++) begin
            r.rst_n    = ($urandom_range(0, 63) != 0);
            r.id_valid = ($urandom_range(0, 3) != 0);
            r.id_rs    = 5'($urandom_range(0, 3));
            r.id_rt    = 5'($urandom_range(0, 3));
            r.use_rs   = 1'($urandom);
            r.use_rt   = 1'($urandom);
            r.mem_read = 1'($urandom);
            r.ex_dst   = 5'($urandom_range(0, 3));
            r.mdu      = ($urandom_range(0, 9) == 0);
            r.br       = ($urandom_range(0, 7) == 0);
            r.exp      = '0;
            step(r, 1'b0, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
